// File: rtl/seg_scan_pkg.sv
// Segment pattern constants and the hex-to-7-segment lookup shared by the scan driver.
// Pattern bit order is {a,b,c,d,e,f,g,dp}, active-high. The dp bit is always 0 here.
package seg_scan_pkg;

  localparam logic [7:0] SEG_0     = 8'hfc;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hda;
  localparam logic [7:0] SEG_3     = 8'hf2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hb6;
  localparam logic [7:0] SEG_6     = 8'hbe;
  localparam logic [7:0] SEG_7     = 8'he0;
  localparam logic [7:0] SEG_8     = 8'hfe;
  localparam logic [7:0] SEG_9     = 8'hf6;
  localparam logic [7:0] SEG_A     = 8'hee;
  localparam logic [7:0] SEG_B     = 8'h3e;
  localparam logic [7:0] SEG_C     = 8'h9c;
  localparam logic [7:0] SEG_D     = 8'h7a;
  localparam logic [7:0] SEG_E     = 8'h9e;
  localparam logic [7:0] SEG_F     = 8'h8e;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'ha: pat = SEG_A;
      4'hb: pat = SEG_B;
      4'hc: pat = SEG_C;
      4'hd: pat = SEG_D;
      4'he: pat = SEG_E;
      4'hf: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Purely combinational nibble to 7-segment pattern lookup.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] pattern_o
);

  assign pattern_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan driver: frame snapshot, per-digit enable, dp, PWM, two segment groups.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the top nonzero nibble).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int GROUP_SIZE = 4,
  parameter int DIV_LOG2   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] show_data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              bright,
  output logic [7:0]              seg,
  output logic [7:0]              seg1,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_LOG2-1:0]     tick_cnt_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    first_q;
  logic [4*NUM_DIGITS-1:0] snap_data_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_en_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d, seg1_q, seg1_d;
  logic                    frame_done_q;

  logic       slot_tick, boundary, visible, lit, upper;
  logic [3:0] nibble, phase;
  logic       cur_dp, cur_en;
  logic [7:0] pattern, digit_pat;

  assign slot_tick = &tick_cnt_q;
  // The first tick after reset restarts at digit 0 instead of advancing, so it opens a frame.
  assign boundary  = slot_tick && (first_q || (idx_q == IDX_W'(NUM_DIGITS - 1)));
  assign phase     = tick_cnt_q[DIV_LOG2-1 -: 4];

  always_comb begin
    idx_d = idx_q;
    if (slot_tick) idx_d = boundary ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    nibble = 4'h0;
    cur_dp = 1'b0;
    cur_en = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble = snap_data_q[4*i +: 4];
        cur_dp = snap_dp_q[i];
        cur_en = snap_en_q[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msnz;

  always_comb begin
    msnz = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (snap_data_q[4*i +: 4] != 4'h0) msnz = IDX_W'(i);
    end
  end

  assign visible = cur_en && ((idx_q <= msnz) || cur_dp);
`else
  assign visible = cur_en;
`endif

  seg_hex_decode u_dec (
    .nib_i     (nibble),
    .pattern_o (pattern)
  );

  assign digit_pat = pattern | {7'b0, cur_dp};
  assign lit       = visible && (phase <= bright);
  assign upper     = 32'(idx_q) >= GROUP_SIZE;

  always_comb begin
    an_d   = '0;
    seg_d  = SEG_BLANK;
    seg1_d = SEG_BLANK;
    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (idx_q == IDX_W'(i));
      if (upper) seg_d  = digit_pat;
      else       seg1_d = digit_pat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      idx_q        <= '0;
      first_q      <= 1'b1;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      snap_en_q    <= '0;
      an_q         <= '0;
      seg_q        <= SEG_BLANK;
      seg1_q       <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_q + 1'b1;
      idx_q        <= idx_d;
      if (slot_tick) first_q <= 1'b0;
      if (boundary) begin
        snap_data_q <= show_data;
        snap_dp_q   <= dp;
        snap_en_q   <= digit_en;
      end
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg1_q       <= seg1_d;
      frame_done_q <= boundary;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign seg1       = seg1_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (8 digits, groups of 4, 16-cycle slots).
// Expectations follow LEADING_ZERO_BLANK_EN when that macro is defined for the build.
module tb_seg_scan_ctrl;

  typedef struct {
    string           name;
    logic [31:0]     data;
    logic [7:0]      dpIn;
    logic [7:0]      enIn;
    logic [3:0]      brightIn;
    logic [7:0][7:0] segExp;
    logic [7:0][7:0] seg1Exp;
    logic [7:0]      litMask;
    int              litCnt;
    bit              settle;
    int              changeAt;
    logic [31:0]     changeData;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] showData;
  logic [7:0]  dpIn;
  logic [7:0]  digitEn;
  logic [3:0]  brightIn;
  logic [7:0]  seg;
  logic [7:0]  seg1;
  logic [7:0]  an;
  logic        frameDone;

  int   nCheck = 0;
  int   nFail  = 0;
  vec_t vec[8];

  seg_scan_ctrl #(
    .NUM_DIGITS (8),
    .GROUP_SIZE (4),
    .DIV_LOG2   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .show_data  (showData),
    .dp         (dpIn),
    .digit_en   (digitEn),
    .bright     (brightIn),
    .seg        (seg),
    .seg1       (seg1),
    .an         (an),
    .frame_done (frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [31:0] d, logic [7:0] p, logic [7:0] e,
                              logic [3:0] b, logic [63:0] sE, logic [63:0] s1E,
                              logic [7:0] m, int lc, bit st, int chAt, logic [31:0] chD);
    vec_t v;
    v.name = n; v.data = d; v.dpIn = p; v.enIn = e; v.brightIn = b;
    v.segExp = sE; v.seg1Exp = s1E; v.litMask = m; v.litCnt = lc;
    v.settle = st; v.changeAt = chAt; v.changeData = chD;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCheck++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    showData = v.data;
    dpIn     = v.dpIn;
    digitEn  = v.enIn;
    brightIn = v.brightIn;
  endtask

  // Steps negedges until frame_done is seen or the budget runs out; also counts lit cycles.
  task automatic waitFrame(input int maxCycles, output int cnt, output int litSeen);
    cnt = 0;
    litSeen = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (an != 8'h00) litSeen++;
    end while (frameDone !== 1'b1 && cnt < maxCycles);
  endtask

  task automatic settleFrame(input string name);
    int cnt, litSeen;
    waitFrame(200, cnt, litSeen);
    checkOutput({name, "_settle_period"}, cnt, 128);
  endtask

  // Starts on the negedge where frame_done is visible and walks one full 128-cycle frame.
  task automatic checkFrame(input vec_t v);
    int d, ph, lit, bad, pulses;
    logic [7:0] expAn;
    pulses = 0; lit = 0; bad = 0;
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      d  = (j - 1) / 16;
      ph = (j - 1) % 16;
      expAn = v.litMask[d] ? 8'(1 << d) : 8'h00;
      if (ph == 0) begin
        lit = 0;
        bad = 0;
        checkOutput($sformatf("%s_d%0d_seg", v.name, d), {24'h0, seg}, {24'h0, v.segExp[d]});
        checkOutput($sformatf("%s_d%0d_seg1", v.name, d), {24'h0, seg1}, {24'h0, v.seg1Exp[d]});
      end
      if (an != 8'h00) lit++;
      if (an != 8'h00 && an != expAn) bad++;
      if (ph == 15) begin
        checkOutput($sformatf("%s_d%0d_lit", v.name, d), lit, v.litMask[d] ? v.litCnt : 0);
        checkOutput($sformatf("%s_d%0d_wrong_an", v.name, d), bad, 0);
        if (!v.litMask[d] || v.litCnt < 15)
          checkOutput($sformatf("%s_d%0d_dark_bus", v.name, d), {16'h0, seg, seg1}, 0);
      end
      if (j < 128 && frameDone) pulses++;
      if (j == v.changeAt) showData = v.changeData;
    end
    checkOutput({v.name, "_frame_done"}, {31'h0, frameDone}, 1);
    checkOutput({v.name, "_extra_pulses"}, pulses, 0);
  endtask

  initial begin
    int cnt, litSeen;

    vec[0] = mk("walk", 32'h1234_5678, 8'h00, 8'hFF, 4'd15, 64'h60daf266_00000000,
                64'h00000000_b6bee0fe, 8'hFF, 16, 0, 0, 32'h0);
    vec[1] = mk("snapshot", 32'h1234_5678, 8'h00, 8'hFF, 4'd15, 64'h60daf266_00000000,
                64'h00000000_b6bee0fe, 8'hFF, 16, 1, 50, 32'hFFFF_FFFF);
    vec[2] = mk("allF", 32'hFFFF_FFFF, 8'h00, 8'hFF, 4'd15, 64'h8e8e8e8e_00000000,
                64'h00000000_8e8e8e8e, 8'hFF, 16, 0, 0, 32'h0);
    vec[3] = mk("bright0", 32'hFFFF_FFFF, 8'h00, 8'hFF, 4'd0, 64'h8e8e8e8e_00000000,
                64'h00000000_8e8e8e8e, 8'hFF, 1, 0, 0, 32'h0);
    vec[4] = mk("bright7", 32'hFFFF_FFFF, 8'h00, 8'hFF, 4'd7, 64'h8e8e8e8e_00000000,
                64'h00000000_8e8e8e8e, 8'hFF, 8, 0, 0, 32'h0);
    vec[5] = mk("enable", 32'hFFFF_FFFF, 8'h01, 8'h0F, 4'd15, 64'h0,
                64'h00000000_8e8e8e8f, 8'h0F, 16, 1, 0, 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
    vec[6] = mk("lzbA0", 32'h0000_00A0, 8'h00, 8'hFF, 4'd15, 64'h0,
                64'h00000000_0000eefc, 8'h03, 16, 1, 0, 32'h0);
    vec[7] = mk("lzb0", 32'h0, 8'h00, 8'hFF, 4'd15, 64'h0,
                64'h00000000_000000fc, 8'h01, 16, 1, 0, 32'h0);
`else
    vec[6] = mk("lzbA0", 32'h0000_00A0, 8'h00, 8'hFF, 4'd15, 64'hfcfcfcfc_00000000,
                64'h00000000_fcfceefc, 8'hFF, 16, 1, 0, 32'h0);
    vec[7] = mk("lzb0", 32'h0, 8'h00, 8'hFF, 4'd15, 64'hfcfcfcfc_00000000,
                64'h00000000_fcfcfcfc, 8'hFF, 16, 1, 0, 32'h0);
`endif

    rst = 1'b1;
    applyStimulus(vec[0]);
    repeat (3) @(negedge clk);
    checkOutput("reset_an", {24'h0, an}, 0);
    checkOutput("reset_seg", {24'h0, seg}, 0);
    checkOutput("reset_seg1", {24'h0, seg1}, 0);
    checkOutput("reset_frame_done", {31'h0, frameDone}, 0);
    rst = 1'b0;

    waitFrame(64, cnt, litSeen);
    checkOutput("first_frame_done", {31'h0, frameDone}, 1);
    checkOutput("first_frame_delay", cnt, 16);
    checkOutput("first_frame_dark", litSeen, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vec[i]);
      if (vec[i].settle) settleFrame(vec[i].name);
      checkFrame(vec[i]);
    end

    // Reset pulse in the middle of digit 5's slot.
    repeat (88) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("pre_reset_an", {24'h0, an}, 32'h00);
`else
    checkOutput("pre_reset_an", {24'h0, an}, 32'h20);
`endif
    rst = 1'b1;
    #1;
    checkOutput("midreset_an", {24'h0, an}, 0);
    checkOutput("midreset_seg", {24'h0, seg}, 0);
    checkOutput("midreset_seg1", {24'h0, seg1}, 0);
    @(negedge clk);
    rst = 1'b0;
    waitFrame(64, cnt, litSeen);
    checkOutput("restart_frame_done", {31'h0, frameDone}, 1);
    checkOutput("restart_delay", cnt, 16);
    checkOutput("restart_dark", litSeen, 0);
    @(negedge clk);
    checkOutput("restart_an", {24'h0, an}, 32'h01);
    checkOutput("restart_seg1", {24'h0, seg1}, 32'hfc);
    checkOutput("restart_seg", {24'h0, seg}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nCheck, nFail);
    $finish;
  end

endmodule
